fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Shares the single write port of the dual-clock framebuffer SRAM between two write requesters, A and B, using round-robin arbitration.
- Adds a built-in clear sequencer that fills every location with a programmable value.
- Sits in the i_clkWrite domain. Its registered outputs drive the SRAM i_writeAddr, i_writeEnable and i_dataIn pins directly.
- The SRAM captures writes on the falling edge of i_clk. Values registered on the rising edge are therefore stable half a cycle before capture.

Parameters:
ADDR_WIDTH, 8, width of all addresses; must match the SRAM.
DATA_WIDTH, 8, pixel/data word width; must match the SRAM.
DEPTH, 256, number of SRAM locations to clear; DEPTH <= 2**ADDR_WIDTH.

Ports:
i_clk  in  1  system/write clock; same net as the SRAM i_clkWrite.
i_rstN  in  1  asynchronous active-low reset.
i_reqA  in  1  requester A write request (valid).
i_addrA  in  ADDR_WIDTH  requester A address.
i_dataA  in  DATA_WIDTH  requester A data.
o_ackA  out  1  requester A ready; a transfer occurs on the rising edge where i_reqA && o_ackA.
i_reqB  in  1  requester B write request.
i_addrB  in  ADDR_WIDTH  requester B address.
i_dataB  in  DATA_WIDTH  requester B data.
o_ackB  out  1  requester B ready.
i_clearReq  in  1  one-cycle pulse that starts a full-memory clear.
i_clearValue  in  DATA_WIDTH  fill value; sampled on the cycle the clear starts.
o_busy  out  1  high while a clear is pending or running.
o_clearDone  out  1  one-cycle pulse after the last clear write.
o_writeAddr  out  ADDR_WIDTH  to SRAM i_writeAddr.
o_writeEnable  out  1  to SRAM i_writeEnable.
o_dataOut  out  DATA_WIDTH  to SRAM i_dataIn.

Behaviour:
- Reset (async, i_rstN=0):
  - State goes to IDLE; clear-pending, counter and fill register go to 0.
  - lastGrant is set to B, so A wins the first tie.
  - o_writeEnable, o_writeAddr, o_dataOut, o_clearDone and o_busy go to 0.
  - Acks are 0 while in reset.
  - Reset in the middle of a clear abandons it; no o_clearDone is issued.
- States: IDLE, CLEAR.
- IDLE, ack generation (combinational from state, pending and lastGrant):
  - Only A requests: o_ackA=1.
  - Only B requests: o_ackB=1.
  - Both request: grant the requester not in lastGrant.
  - At most one ack is high per cycle. Both acks are 0 whenever clear-pending=1.
- IDLE, transfer: on a granted edge, o_writeAddr/o_dataOut take the granted address/data, o_writeEnable=1 for exactly the next cycle, and lastGrant is updated.
- Write latency: one cycle. The request is accepted at edge N and written to the SRAM at the falling edge within cycle N+1.
- Throughput: one write per cycle. With both requesters held high, grants alternate A, B, A, B.
- No transfer in a cycle: o_writeEnable=0. Address and data hold their last values.
- Requesters must hold address/data stable while req=1 and ack=0.
- i_clearReq:
  - Sets clear-pending.
  - Clear has priority over requests: on the next edge in IDLE with pending=1, go to CLEAR, capture i_clearValue, set counter=0 and clear pending.
  - A write accepted on the same edge as the i_clearReq pulse still completes; it is already registered.
- CLEAR:
  - Each cycle: o_writeEnable=1, o_writeAddr=counter, o_dataOut=fill; counter increments.
  - After address DEPTH-1 has been issued, return to IDLE and pulse o_clearDone for one cycle, concurrent with the first IDLE cycle.
  - A clear takes DEPTH cycles in total.
  - Acks are 0 throughout CLEAR.
  - An i_clearReq arriving during CLEAR is ignored (not latched).
- o_busy = pending | (state==CLEAR), registered.
- Counter is ADDR_WIDTH+1 bits wide so DEPTH = 2**ADDR_WIDTH terminates without wrap. o_writeAddr uses the low ADDR_WIDTH bits.

Decomposition:
- Shared package fb_pkg holds the state encodings (ST_IDLE=1'b0, ST_CLEAR=1'b1) and grant IDs (GNT_A, GNT_B) as localparams.
- Natural sub-module: rr_arb2, a two-input round-robin grant with a lastGrant register. It takes req[1:0] and an enable, and produces a one-hot grant[1:0].
- The clear FSM and output register stay in fb_write_arbiter.

Test Plan:
- Reset, then A writes addr 0x10, data 0x55: o_ackA=1 the same cycle; next cycle o_writeEnable=1, o_writeAddr=0x10, o_dataOut=0x55; the SRAM reads back 0x55.
- A and B both held high for 4 cycles (A: 0x01..0x04, B: 0x81..0x84): grant order is A, B, A, B; the SRAM contains A's first two and B's first two writes.
- i_clearReq with i_clearValue=0x3C and DEPTH=256:
  - exactly 256 consecutive o_writeEnable cycles, addresses 0..255;
  - o_clearDone pulses once;
  - every SRAM location reads 0x3C.
- i_reqA held high during a clear: o_ackA=0 for the entire clear; A is acknowledged on the first IDLE cycle; the A data is not overwritten by the fill.
- i_clearReq on the same edge as an accepted B write (addr 0x20, data 0x99), then a second i_clearReq at cycle 100 of the clear:
  - 0x99 is written before the clear starts;
  - only one clear runs;
  - exactly one o_clearDone.
- i_rstN asserted at cycle 50 of a clear: all outputs go to 0 immediately; no o_clearDone; after release, the first A request is granted.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared encodings for the framebuffer write arbiter.
package fb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Grant IDs held in the round-robin lastGrant register
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, favours the requester not granted last.
module rr_arb2
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // Grant selection and lastGrant update
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req == 2'b11) begin
                grant = (last_q == GNT_B) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
        if (grant[0]) begin
            last_d = GNT_A;
        end else if (grant[1]) begin
            last_d = GNT_B;
        end
    end

    // lastGrant register; B after reset so A wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer SRAM write-port arbiter: round-robin A/B plus full-memory clear sequencer.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rstN,
    input  logic                  i_reqA,
    input  logic [ADDR_WIDTH-1:0] i_addrA,
    input  logic [DATA_WIDTH-1:0] i_dataA,
    output logic                  o_ackA,
    input  logic                  i_reqB,
    input  logic [ADDR_WIDTH-1:0] i_addrB,
    input  logic [DATA_WIDTH-1:0] i_dataB,
    output logic                  o_ackB,
    input  logic                  i_clearReq,
    input  logic [DATA_WIDTH-1:0] i_clearValue,
    output logic                  o_busy,
    output logic                  o_clearDone,
    output logic [ADDR_WIDTH-1:0] o_writeAddr,
    output logic                  o_writeEnable,
    output logic [DATA_WIDTH-1:0] o_dataOut
);

    // One extra counter bit so DEPTH == 2**ADDR_WIDTH terminates without wrapping
    localparam int unsigned   CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    state_e                state_q,   state_d;
    logic                  pending_q, pending_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] fill_q,    fill_d;
    logic                  we_q,      we_d;
    logic [ADDR_WIDTH-1:0] waddr_q,   waddr_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  done_q,    done_d;
    logic                  busy_q,    busy_d;

    logic                  arb_en;
    logic [1:0]            grant;

    // Requesters only see a grant in IDLE with no clear pending, and never in reset
    assign arb_en = i_rstN && (state_q == ST_IDLE) && !pending_q;

    rr_arb2 u_arb (
        .clk   (i_clk),
        .rst_n (i_rstN),
        .req   ({i_reqB, i_reqA}),
        .en    (arb_en),
        .grant (grant)
    );

    assign o_ackA        = grant[0];
    assign o_ackB        = grant[1];
    assign o_writeEnable = we_q;
    assign o_writeAddr   = waddr_q;
    assign o_dataOut     = data_q;
    assign o_clearDone   = done_q;
    assign o_busy        = busy_q;

    // Next-state and registered SRAM write-port outputs
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        data_d    = data_q;
        done_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (pending_q) begin
                state_d   = ST_CLEAR;
                fill_d    = i_clearValue;
                cnt_d     = '0;
                pending_d = 1'b0;
            end else begin
                if (i_clearReq) begin
                    pending_d = 1'b1;
                end
                if (grant[0]) begin
                    we_d    = 1'b1;
                    waddr_d = i_addrA;
                    data_d  = i_dataA;
                end else if (grant[1]) begin
                    we_d    = 1'b1;
                    waddr_d = i_addrB;
                    data_d  = i_dataB;
                end
            end
        end else begin
            we_d    = 1'b1;
            waddr_d = cnt_q[ADDR_WIDTH-1:0];
            data_d  = fill_q;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end

        busy_d = pending_d | (state_d == ST_CLEAR);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            fill_q    <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a falling-edge SRAM model.
module tb_fb_write_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b, ack_a, ack_b;
    logic [7:0] addr_a, addr_b, data_a, data_b;
    logic       clear_req;
    logic [7:0] clear_value;
    logic       busy, clear_done, we;
    logic [7:0] waddr, dout;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    fb_write_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256)) dut (
        .i_clk         (clk),
        .i_rstN        (rst_n),
        .i_reqA        (req_a),
        .i_addrA       (addr_a),
        .i_dataA       (data_a),
        .o_ackA        (ack_a),
        .i_reqB        (req_b),
        .i_addrB       (addr_b),
        .i_dataB       (data_b),
        .o_ackB        (ack_b),
        .i_clearReq    (clear_req),
        .i_clearValue  (clear_value),
        .o_busy        (busy),
        .o_clearDone   (clear_done),
        .o_writeAddr   (waddr),
        .o_writeEnable (we),
        .o_dataOut     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM write port captures on the falling edge
    always @(negedge clk) begin
        if (we) mem[waddr] <= dout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0; addr_a = 8'h00; addr_b = 8'h00;
        data_a = 8'h00; data_b = 8'h00; clear_req = 1'b0; clear_value = 8'h00;
        #12;
        checks++;
        if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
            errors++; $display("FAIL reset_ack: ack_a=%b ack_b=%b expected 0 0", ack_a, ack_b);
        end
        checks++;
        if (we !== 1'b0 || waddr !== 8'h00 || dout !== 8'h00 || busy !== 1'b0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h busy=%b done=%b expected all 0",
                     we, waddr, dout, busy, clear_done);
        end
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        req_a = 1'b1; addr_a = 8'h10; data_a = 8'h55;
        #1;
        checks++;
        if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
            errors++; $display("FAIL single_ack: ack_a=%b ack_b=%b expected 1 0", ack_a, ack_b);
        end
        tick();
        req_a = 1'b0;
        checks++;
        if (we !== 1'b1 || waddr !== 8'h10 || dout !== 8'h55) begin
            errors++; $display("FAIL single_write: we=%b addr=%h data=%h expected 1 10 55", we, waddr, dout);
        end
        tick();
        checks++;
        if (we !== 1'b0 || waddr !== 8'h10 || dout !== 8'h55) begin
            errors++; $display("FAIL single_idle_hold: we=%b addr=%h data=%h expected 0 10 55", we, waddr, dout);
        end
        checks++;
        if (mem[8'h10] !== 8'h55) begin
            errors++; $display("FAIL single_sram: mem[10]=%h expected 55", mem[8'h10]);
        end
    endtask

    task automatic test_alternate();
        int ia = 0;
        int ib = 0;
        logic exp_a;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_a = 1'b1; req_b = 1'b1;
            addr_a = 8'(32'h40 + ia); data_a = 8'(32'h01 + ia);
            addr_b = 8'(32'h50 + ib); data_b = 8'(32'h81 + ib);
            #1;
            exp_a = (k % 2 == 0);
            checks++;
            if (ack_a !== exp_a || ack_b !== !exp_a) begin
                errors++;
                $display("FAIL alt_grant[%0d]: ack_a=%b ack_b=%b expected %b %b", k, ack_a, ack_b, exp_a, !exp_a);
            end
            tick();
            checks++;
            if (exp_a) begin
                if (we !== 1'b1 || waddr !== addr_a || dout !== data_a) begin
                    errors++; $display("FAIL alt_write[%0d]: we=%b addr=%h data=%h expected 1 %h %h",
                                       k, we, waddr, dout, addr_a, data_a);
                end
                ia++;
            end else begin
                if (we !== 1'b1 || waddr !== addr_b || dout !== data_b) begin
                    errors++; $display("FAIL alt_write[%0d]: we=%b addr=%h data=%h expected 1 %h %h",
                                       k, we, waddr, dout, addr_b, data_b);
                end
                ib++;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        checks++;
        if (mem[8'h40] !== 8'h01 || mem[8'h41] !== 8'h02 || mem[8'h50] !== 8'h81 || mem[8'h51] !== 8'h82) begin
            errors++;
            $display("FAIL alt_sram: 40=%h 41=%h 50=%h 51=%h expected 01 02 81 82",
                     mem[8'h40], mem[8'h41], mem[8'h50], mem[8'h51]);
        end
    endtask

    task automatic test_clear();
        int we_cnt = 0, done_cnt = 0, bad_addr = 0, first_c = -1, last_c = -1, bad_mem = 0;
        bit seen_done = 0;
        clear_value = 8'h3C; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL clear_busy_pending: busy=%b expected 1", busy);
        end
        for (int c = 0; c < 400 && !seen_done; c++) begin
            tick();
            if (we) begin
                if (waddr !== 8'(we_cnt)) bad_addr++;
                if (first_c < 0) first_c = c;
                last_c = c;
                we_cnt++;
            end
            if (clear_done) begin
                done_cnt++;
                seen_done = 1;
            end
        end
        checks++;
        if (!seen_done) begin
            errors++; $display("FAIL clear_timeout: clear_done=0 after 400 cycles expected pulse");
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (clear_done) done_cnt++;
            if (we) we_cnt++;
        end
        checks++;
        if (we_cnt != 256 || (last_c - first_c + 1) != 256) begin
            errors++; $display("FAIL clear_we_count: writes=%0d span=%0d expected 256 256",
                               we_cnt, last_c - first_c + 1);
        end
        checks++;
        if (bad_addr != 0) begin
            errors++; $display("FAIL clear_addr_seq: out_of_order=%0d expected 0", bad_addr);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL clear_done_count: pulses=%0d expected 1", done_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL clear_busy_end: busy=%b expected 0", busy);
        end
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== 8'h3C) bad_mem++;
        end
        checks++;
        if (bad_mem != 0) begin
            errors++; $display("FAIL clear_sram_fill: wrong_locations=%0d expected 0", bad_mem);
        end
    endtask

    task automatic test_hold_during_clear();
        int bad_ack = 0;
        bit seen_done = 0;
        clear_value = 8'h11; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        req_a = 1'b1; addr_a = 8'h05; data_a = 8'hA5;
        #1;
        for (int c = 0; c < 400; c++) begin
            if (clear_done) begin
                seen_done = 1;
                break;
            end
            if (ack_a !== 1'b0) bad_ack++;
            tick();
            #1;
        end
        checks++;
        if (bad_ack != 0) begin
            errors++; $display("FAIL hold_ack_during_clear: ack_cycles=%0d expected 0", bad_ack);
        end
        checks++;
        if (!seen_done || ack_a !== 1'b1) begin
            errors++; $display("FAIL hold_ack_first_idle: done_seen=%0d ack_a=%b expected 1 1", seen_done, ack_a);
        end
        tick();
        req_a = 1'b0;
        checks++;
        if (we !== 1'b1 || waddr !== 8'h05 || dout !== 8'hA5) begin
            errors++; $display("FAIL hold_write: we=%b addr=%h data=%h expected 1 05 a5", we, waddr, dout);
        end
        tick();
        checks++;
        if (mem[8'h05] !== 8'hA5 || mem[8'h06] !== 8'h11) begin
            errors++; $display("FAIL hold_sram: mem[05]=%h mem[06]=%h expected a5 11", mem[8'h05], mem[8'h06]);
        end
    endtask

    task automatic test_clear_with_write();
        int we_cnt = 0, done_cnt = 0;
        req_b = 1'b1; addr_b = 8'h20; data_b = 8'h99;
        clear_req = 1'b1; clear_value = 8'h77;
        #1;
        checks++;
        if (ack_b !== 1'b1 || ack_a !== 1'b0) begin
            errors++; $display("FAIL cw_ack_b: ack_a=%b ack_b=%b expected 0 1", ack_a, ack_b);
        end
        tick();
        req_b = 1'b0; clear_req = 1'b0;
        checks++;
        if (we !== 1'b1 || waddr !== 8'h20 || dout !== 8'h99 || busy !== 1'b1) begin
            errors++; $display("FAIL cw_b_write: we=%b addr=%h data=%h busy=%b expected 1 20 99 1",
                               we, waddr, dout, busy);
        end
        tick();
        checks++;
        if (mem[8'h20] !== 8'h99) begin
            errors++; $display("FAIL cw_b_before_clear: mem[20]=%h expected 99", mem[8'h20]);
        end
        for (int c = 0; c < 600; c++) begin
            clear_req = (c == 100);
            tick();
            if (we) we_cnt++;
            if (clear_done) done_cnt++;
        end
        clear_req = 1'b0;
        checks++;
        if (we_cnt != 256) begin
            errors++; $display("FAIL cw_single_clear: writes=%0d expected 256", we_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL cw_done_count: pulses=%0d expected 1", done_cnt);
        end
        checks++;
        if (mem[8'h20] !== 8'h77) begin
            errors++; $display("FAIL cw_fill_after: mem[20]=%h expected 77", mem[8'h20]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int we_cnt = 0, done_cnt = 0;
        clear_value = 8'hE1; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (51) tick();
        checks++;
        if (we !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_running: we=%b busy=%b expected 1 1", we, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || waddr !== 8'h00 || dout !== 8'h00 || busy !== 1'b0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: we=%b addr=%h data=%h busy=%b done=%b expected all 0",
                     we, waddr, dout, busy, clear_done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (we) we_cnt++;
            if (clear_done) done_cnt++;
        end
        checks++;
        if (we_cnt != 0 || done_cnt != 0) begin
            errors++; $display("FAIL rst_mid_abandon: writes=%0d done=%0d expected 0 0", we_cnt, done_cnt);
        end
        req_a = 1'b1; addr_a = 8'h33; data_a = 8'h44;
        req_b = 1'b1; addr_b = 8'h66; data_b = 8'h77;
        #1;
        checks++;
        if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
            errors++; $display("FAIL rst_mid_first_grant: ack_a=%b ack_b=%b expected 1 0", ack_a, ack_b);
        end
        tick();
        req_a = 1'b0; req_b = 1'b0;
        checks++;
        if (we !== 1'b1 || waddr !== 8'h33 || dout !== 8'h44) begin
            errors++; $display("FAIL rst_mid_a_write: we=%b addr=%h data=%h expected 1 33 44", we, waddr, dout);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_alternate();
        test_clear();
        test_hold_during_clear();
        test_clear_with_write();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
